axis_maxpool_relu: RTL and testbench
====================================

Name: axis_maxpool_relu

Overview:
- Streaming 2x2 stride-2 max-pool with optional ReLU, placed directly downstream of the convolution controller's AXIS master port.
- Consumes signed 32-bit convolution sums in pixel-major, channel-minor, row-major order: CHANNELS words per output pixel.
- Emits the pooled feature map on an AXIS master port in the same ordering, ready for the next layer or DMA.

Parameters:
- AXI_BUS_WIDTH, 32, data word width; data is two's-complement signed.
- CHANNELS, 3, words per pixel, interleaved.
- MAX_ROW_WIDTH, 1800, maximum input map width in pixels; sizes the line buffer to (MAX_ROW_WIDTH/2)*CHANNELS words.
- DIM_WIDTH, 16, width of the dimension inputs.

Ports:
- axi_clk  in  1  clock.
- axi_reset_n  in  1  asynchronous active-low reset.
- cfg_width  in  DIM_WIDTH  input map width in pixels (conv output width); sampled at frame start.
- cfg_height  in  DIM_WIDTH  input map height in pixels; sampled at frame start.
- cfg_relu_en  in  1  1 = clamp negative results to 0; sampled at frame start.
- err_clr  in  1  clears err_last.
- s_axis_valid  in  1  input beat valid.
- s_axis_data  in  AXI_BUS_WIDTH  input conv sum.
- s_axis_last  in  1  final beat of the input frame.
- s_axis_keep  in  4  ignored.
- s_axis_ready  out  1  input accepted.
- m_axis_valid  out  1  output beat valid.
- m_axis_data  out  AXI_BUS_WIDTH  pooled value.
- m_axis_last  out  1  final pooled beat of the frame.
- m_axis_keep  out  4  4'hF whenever m_axis_valid.
- m_axis_ready  in  1  downstream accept.
- frame_done  out  1  one-cycle pulse when the m_axis_last beat is accepted.
- err_last  out  1  sticky; s_axis_last position mismatch.

Behaviour:
- Reset (async assert, sync deassert) clears all counters, pipeline valids, m_axis_valid/last/data, frame_done, err_last; m_axis_keep=0. Line buffer contents are don't-care.
- Counters: ch (0..CHANNELS-1), x (0..W-1), y (0..H-1); they advance on each accepted input beat. Frame start is the first accepted beat with all counters at 0; W, H and relu are latched then.
- advance = !m_axis_valid | m_axis_ready. s_axis_ready = advance. All pipeline stages and the BRAM read-enable hold when !advance.
- Stage 1, accepted beat:
  - x even: store value in hold[ch].
  - x odd: hmax = signed max(hold[ch], value).
  - y even, x odd: write hmax to lbuf[(x>>1)*CHANNELS+ch].
  - y odd, x odd: issue a synchronous read of the same address and register hmax plus an emit flag.
- Stage 2: out = signed max(lbuf_rd, hmax); if relu and out<0, out=0. Load the m_axis register.
- Latency: accepted emitting beat at cycle N -> m_axis_valid at N+2 with no stall. Full throughput of 1 beat/cycle.
- Output occurs only at (x odd, y odd). A trailing odd column (x=W-1, W odd) and a trailing odd row (H odd) are consumed and discarded; the pool floors.
- Output count per frame = floor(W/2)*floor(H/2)*CHANNELS.
- m_axis_last asserts on the output word with x=2*floor(W/2)-1, y=2*floor(H/2)-1, ch=CHANNELS-1.
  - If W<2 or H<2, nothing is emitted and frame_done pulses when the final input beat is accepted.
- Frame end: the expected last input beat is (x=W-1, y=H-1, ch=CHANNELS-1); counters wrap to 0 after it.
  - If s_axis_last arrives on any other beat, set err_last and reset counters to 0 after that beat.
  - If the expected last beat arrives without s_axis_last, set err_last and still wrap.
  - A pending pooled output already in the pipeline is still emitted. m_axis_last is not forced.
- Same-cycle events: a line-buffer write (row even) and read (row odd) never coincide. err_clr with a new error: the error wins.
- Mid-frame reset: all state cleared and the partial frame discarded. The next accepted beat is treated as a frame start.

Test Plan:
- W=4, H=4, CHANNELS=1, relu=0, input 1..16 row-major -> outputs 6, 8, 14, 16; m_axis_last on 16; frame_done one pulse; each first output 2 cycles after its triggering input.
- Same frame negated (-1..-16), relu=1 -> four outputs of 0. With relu=0 -> -1, -3, -9, -11.
- CHANNELS=3, W=2, H=2, pixel p channel c value = 10*p+c (p=0..3) -> outputs 30, 31, 32, last on 32.
- W=5, H=3, CHANNELS=1, input 1..15 -> outputs 7, 9, last on 9; column 5 and row 3 discarded.
- Stream of the first test with m_axis_ready toggling 1,0,0,1,... and random s_axis_valid gaps -> identical output sequence, no beat lost or duplicated, m_axis_data stable while stalled.
- s_axis_last on beat 10 of a 4x4 frame -> err_last=1; the next frame of 16 beats pools correctly; err_clr clears err_last. Reset asserted mid-frame -> all outputs 0 immediately and the following frame is correct.

Source files
------------

// File: rtl/axis_maxpool_relu.sv
// Streaming 2x2 stride-2 signed max-pool with optional ReLU on an AXIS stream.
// Input order is row-major, pixel-major, channel-minor. Horizontal pairs are
// reduced into a per-channel hold register. Even rows park their pair maxima
// in a line buffer, and odd rows read those maxima back to emit one pooled word.
module axis_maxpool_relu #(
   parameter int AXI_BUS_WIDTH = 32,
   parameter int CHANNELS      = 3,
   parameter int MAX_ROW_WIDTH = 1800,
   parameter int DIM_WIDTH     = 16
) (
   input  logic                     axi_clk,
   input  logic                     axi_reset_n,
   input  logic [DIM_WIDTH-1:0]     cfg_width,
   input  logic [DIM_WIDTH-1:0]     cfg_height,
   input  logic                     cfg_relu_en,
   input  logic                     err_clr,
   input  logic                     s_axis_valid,
   input  logic [AXI_BUS_WIDTH-1:0] s_axis_data,
   input  logic                     s_axis_last,
   input  logic [3:0]               s_axis_keep,
   output logic                     s_axis_ready,
   output logic                     m_axis_valid,
   output logic [AXI_BUS_WIDTH-1:0] m_axis_data,
   output logic                     m_axis_last,
   output logic [3:0]               m_axis_keep,
   input  logic                     m_axis_ready,
   output logic                     frame_done,
   output logic                     err_last
);

   localparam int LBUF_DEPTH = (MAX_ROW_WIDTH / 2) * CHANNELS;
   localparam int ADDR_W     = (LBUF_DEPTH > 1) ? $clog2(LBUF_DEPTH) : 1;
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                     advance;
   logic                     accept;
   logic [CH_W-1:0]          ch;
   logic [DIM_WIDTH-1:0]     x;
   logic [DIM_WIDTH-1:0]     y;
   logic [DIM_WIDTH-1:0]     w_q;
   logic [DIM_WIDTH-1:0]     h_q;
   logic                     relu_q;
   logic                     frame_start;
   logic [DIM_WIDTH-1:0]     w_cur;
   logic [DIM_WIDTH-1:0]     h_cur;
   logic                     relu_cur;
   logic                     ch_last;
   logic                     x_last;
   logic                     y_last;
   logic                     beat_last;
   logic                     small_frame;
   logic [DIM_WIDTH-1:0]     x_pool_last;
   logic [DIM_WIDTH-1:0]     y_pool_last;
   logic [AXI_BUS_WIDTH-1:0] hold [2**CH_W];
   logic [AXI_BUS_WIDTH-1:0] lbuf [LBUF_DEPTH];
   logic [ADDR_W-1:0]        lbuf_addr;
   logic [AXI_BUS_WIDTH-1:0] lbuf_rd;
   logic [AXI_BUS_WIDTH-1:0] hold_cur;
   logic [AXI_BUS_WIDTH-1:0] hmax;
   logic                     lbuf_we;
   logic                     emit;
   logic                     s1_valid;
   logic                     s1_last;
   logic                     s1_relu;
   logic [AXI_BUS_WIDTH-1:0] s1_hmax;
   logic [AXI_BUS_WIDTH-1:0] pooled;
   logic [AXI_BUS_WIDTH-1:0] result;
   logic                     unused_keep;

   assign unused_keep  = ^s_axis_keep;

   assign advance      = !m_axis_valid || m_axis_ready;
   assign s_axis_ready = advance;
   assign accept       = s_axis_valid && advance;
   assign m_axis_keep  = m_axis_valid ? '1 : '0;

   // The frame-start beat must use live configuration, because the latched copy
   // only updates on that same edge.
   assign frame_start  = (ch == '0) && (x == '0) && (y == '0);
   assign w_cur        = frame_start ? cfg_width   : w_q;
   assign h_cur        = frame_start ? cfg_height  : h_q;
   assign relu_cur     = frame_start ? cfg_relu_en : relu_q;

   assign ch_last      = (ch == CH_W'(CHANNELS - 1));
   assign x_last       = (x == w_cur - DIM_WIDTH'(1));
   assign y_last       = (y == h_cur - DIM_WIDTH'(1));
   assign beat_last    = ch_last && x_last && y_last;
   assign small_frame  = (w_cur < DIM_WIDTH'(2)) || (h_cur < DIM_WIDTH'(2));
   assign x_pool_last  = {w_cur[DIM_WIDTH-1:1], 1'b0} - DIM_WIDTH'(1);
   assign y_pool_last  = {h_cur[DIM_WIDTH-1:1], 1'b0} - DIM_WIDTH'(1);

   assign hold_cur     = hold[ch];
   assign hmax         = ($signed(s_axis_data) > $signed(hold_cur)) ? s_axis_data : hold_cur;
   assign lbuf_addr    = ADDR_W'(32'(x[DIM_WIDTH-1:1]) * 32'(CHANNELS) + 32'(ch));
   assign lbuf_we      = accept && x[0] && !y[0];
   assign emit         = accept && x[0] && y[0];

   assign pooled       = ($signed(lbuf_rd) > $signed(s1_hmax)) ? lbuf_rd : s1_hmax;
   assign result       = (s1_relu && pooled[AXI_BUS_WIDTH-1]) ? '0 : pooled;

   // Position counters, frame configuration latch and the sticky last-position error.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         ch       <= '0;
         x        <= '0;
         y        <= '0;
         w_q      <= '0;
         h_q      <= '0;
         relu_q   <= 1'b0;
         err_last <= 1'b0;
      end else begin
         if (accept) begin
            if (frame_start) begin
               w_q    <= cfg_width;
               h_q    <= cfg_height;
               relu_q <= cfg_relu_en;
            end
            if (s_axis_last || beat_last) begin
               ch <= '0;
               x  <= '0;
               y  <= '0;
            end else if (ch_last) begin
               ch <= '0;
               if (x_last) begin
                  x <= '0;
                  y <= y + DIM_WIDTH'(1);
               end else begin
                  x <= x + DIM_WIDTH'(1);
               end
            end else begin
               ch <= ch + CH_W'(1);
            end
         end
         if (accept && (s_axis_last != beat_last))
            err_last <= 1'b1;
         else if (err_clr)
            err_last <= 1'b0;
      end
   end

   // Even columns park their value so the odd column can form the horizontal max.
   always_ff @(posedge axi_clk) begin
      if (accept && !x[0])
         hold[ch] <= s_axis_data;
   end

   // Line buffer: even rows write their pair maxima, odd rows read them back.
   always_ff @(posedge axi_clk) begin
      if (lbuf_we)
         lbuf[lbuf_addr] <= hmax;
      if (emit)
         lbuf_rd <= lbuf[lbuf_addr];
   end

   // Stage 1: capture the odd-row horizontal max alongside the line-buffer read.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_relu  <= 1'b0;
         s1_hmax  <= '0;
      end else if (advance) begin
         s1_valid <= emit;
         if (emit) begin
            s1_hmax <= hmax;
            s1_last <= (x == x_pool_last) && (y == y_pool_last) && ch_last;
            s1_relu <= relu_cur;
         end
      end
   end

   // Stage 2: vertical max, optional clamp, and the output register with frame_done.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         m_axis_valid <= 1'b0;
         m_axis_last  <= 1'b0;
         m_axis_data  <= '0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= (m_axis_valid && m_axis_ready && m_axis_last) ||
                       (accept && beat_last && small_frame);
         if (advance) begin
            m_axis_valid <= s1_valid;
            m_axis_last  <= s1_valid && s1_last;
            if (s1_valid)
               m_axis_data <= result;
         end
      end
   end

endmodule

// File: tb/tb_axis_maxpool_relu.sv
// Bench for axis_maxpool_relu: one instance with a single channel and one with
// three channels. Drivers push expected pooled words into per-instance queues.
// A negedge monitor pops and compares every accepted output beat.
`timescale 1ns/1ps
module tb_axis_maxpool_relu;

   typedef struct packed {
      logic [31:0] d;
      logic        last;
      logic [31:0] cyc;
      logic        chk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        mon_en = 1'b0;
   logic        stall_mode = 1'b0;

   logic [15:0] cfg_w [2];
   logic [15:0] cfg_h [2];
   logic        relu [2];
   logic        err_clr [2];
   logic        s_valid [2];
   logic [31:0] s_data [2];
   logic        s_last [2];
   logic        s_ready [2];
   logic        m_valid [2];
   logic [31:0] m_data [2];
   logic        m_last [2];
   logic [3:0]  m_keep [2];
   logic        m_ready [2];
   logic        frame_done [2];
   logic        err_last [2];

   logic        fd_pend [2];
   logic        prev_st [2];
   logic [31:0] held [2];

   exp_t        q0 [$];
   exp_t        q1 [$];
   int          din [64];
   int          dexp [16];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   axis_maxpool_relu #(
      .AXI_BUS_WIDTH(32), .CHANNELS(1), .MAX_ROW_WIDTH(64), .DIM_WIDTH(16)
   ) dut1 (
      .axi_clk(clk), .axi_reset_n(rst_n),
      .cfg_width(cfg_w[0]), .cfg_height(cfg_h[0]), .cfg_relu_en(relu[0]),
      .err_clr(err_clr[0]),
      .s_axis_valid(s_valid[0]), .s_axis_data(s_data[0]), .s_axis_last(s_last[0]),
      .s_axis_keep(4'hF), .s_axis_ready(s_ready[0]),
      .m_axis_valid(m_valid[0]), .m_axis_data(m_data[0]), .m_axis_last(m_last[0]),
      .m_axis_keep(m_keep[0]), .m_axis_ready(m_ready[0]),
      .frame_done(frame_done[0]), .err_last(err_last[0])
   );

   axis_maxpool_relu #(
      .AXI_BUS_WIDTH(32), .CHANNELS(3), .MAX_ROW_WIDTH(64), .DIM_WIDTH(16)
   ) dut3 (
      .axi_clk(clk), .axi_reset_n(rst_n),
      .cfg_width(cfg_w[1]), .cfg_height(cfg_h[1]), .cfg_relu_en(relu[1]),
      .err_clr(err_clr[1]),
      .s_axis_valid(s_valid[1]), .s_axis_data(s_data[1]), .s_axis_last(s_last[1]),
      .s_axis_keep(4'hF), .s_axis_ready(s_ready[1]),
      .m_axis_valid(m_valid[1]), .m_axis_data(m_data[1]), .m_axis_last(m_last[1]),
      .m_axis_keep(m_keep[1]), .m_axis_ready(m_ready[1]),
      .frame_done(frame_done[1]), .err_last(err_last[1])
   );

   function automatic void check(input string nm, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, expv, $time);
      end
   endfunction

   task automatic mon_step(input int s);
      exp_t e;
      int   sz;
      check("frame_done", int'(frame_done[s]), int'(fd_pend[s]));
      if (prev_st[s] && m_valid[s])
         check("stall_data_stable", m_data[s], held[s]);
      if (m_valid[s])
         check("keep", int'(m_keep[s]), 15);
      if (m_valid[s] && m_ready[s]) begin
         sz = (s == 0) ? q0.size() : q1.size();
         check("expected_pending", (sz > 0) ? 1 : 0, 1);
         if (sz > 0) begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check("data", m_data[s], e.d);
            check("last", int'(m_last[s]), int'(e.last));
            if (e.chk)
               check("latency", cyc, e.cyc);
         end
      end
      fd_pend[s] = m_valid[s] && m_ready[s] && m_last[s];
      prev_st[s] = m_valid[s] && !m_ready[s];
      held[s]    = m_data[s];
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int s = 0; s < 2; s++)
            mon_step(s);
      end
   end

   initial begin
      m_ready[0] = 1'b1;
      m_ready[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready[0] = stall_mode ? ((cyc % 3) == 0) : 1'b1;
      end
   end

   task automatic set_cfg(input int s, input int w, input int h, input logic r);
      cfg_w[s] = 16'(w);
      cfg_h[s] = 16'(h);
      relu[s]  = r;
   endtask

   // Sends din[0..nbeats-1]; s_axis_last rides on beat last_at (-1 = never).
   task automatic send_frame(input int s, input int w, input int h, input int c,
                             input int nbeats, input int last_at,
                             input logic chk_lat, input int gap_max);
      int   x, y, ch, k, n, guard, g;
      logic acc;
      exp_t e;
      x = 0; y = 0; ch = 0; k = 0; n = 0;
      for (int i = 0; i < nbeats; i++) begin
         if (gap_max > 0) begin
            s_valid[s] = 1'b0;
            g = $urandom_range(gap_max, 0);
            repeat (g) begin @(posedge clk); #1; end
         end
         s_valid[s] = 1'b1;
         s_data[s]  = din[i];
         s_last[s]  = (i == last_at);
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            acc = s_ready[s];
            n   = cyc;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 1000) begin
               n_cmp++;
               n_bad++;
               $display("FAIL accept_timeout: s_axis_ready low for %0d cycles, required 1", guard);
               s_valid[s] = 1'b0;
               s_last[s]  = 1'b0;
               return;
            end
         end
         if ((x % 2 == 1) && (y % 2 == 1) && (x < 2 * (w / 2)) && (y < 2 * (h / 2))) begin
            e.d    = dexp[k];
            e.last = (x == 2 * (w / 2) - 1) && (y == 2 * (h / 2) - 1) && (ch == c - 1);
            e.cyc  = n + 2;
            e.chk  = chk_lat;
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
            k++;
         end
         if (ch == c - 1) begin
            ch = 0;
            if (x == w - 1) begin x = 0; y++; end
            else x++;
         end else begin
            ch++;
         end
      end
      s_valid[s] = 1'b0;
      s_last[s]  = 1'b0;
   endtask

   task automatic drain(input int s, input string nm);
      int t;
      int sz;
      t = 0;
      sz = (s == 0) ? q0.size() : q1.size();
      while (sz != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
         sz = (s == 0) ? q0.size() : q1.size();
      end
      check(nm, sz, 0);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic load_ramp(input int n, input int sign);
      for (int i = 0; i < n; i++)
         din[i] = sign * (i + 1);
   endtask

   task automatic set_exp4(input int a, input int b, input int c, input int d);
      dexp[0] = a; dexp[1] = b; dexp[2] = c; dexp[3] = d;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         set_cfg(s, 0, 0, 1'b0);
         err_clr[s] = 1'b0;
         s_valid[s] = 1'b0;
         s_data[s]  = '0;
         s_last[s]  = 1'b0;
         fd_pend[s] = 1'b0;
         prev_st[s] = 1'b0;
         held[s]    = '0;
      end

      repeat (3) begin @(posedge clk); #1; end
      check("reset_m_valid", int'(m_valid[0]), 0);
      check("reset_m_data", m_data[0], 0);
      check("reset_m_last", int'(m_last[0]), 0);
      check("reset_m_keep", int'(m_keep[0]), 0);
      check("reset_frame_done", int'(frame_done[0]), 0);
      check("reset_err_last", int'(err_last[0]), 0);
      check("reset_s_ready", int'(s_ready[0]), 1);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // 4x4 ramp, no ReLU
      set_cfg(0, 4, 4, 1'b0);
      load_ramp(16, 1);
      set_exp4(6, 8, 14, 16);
      send_frame(0, 4, 4, 1, 16, 15, 1'b1, 0);
      drain(0, "drain_4x4");

      // negated ramp with ReLU clamps everything
      set_cfg(0, 4, 4, 1'b1);
      load_ramp(16, -1);
      set_exp4(0, 0, 0, 0);
      send_frame(0, 4, 4, 1, 16, 15, 1'b1, 0);
      drain(0, "drain_neg_relu");

      // negated ramp without ReLU
      set_cfg(0, 4, 4, 1'b0);
      set_exp4(-1, -3, -9, -11);
      send_frame(0, 4, 4, 1, 16, 15, 1'b1, 0);
      drain(0, "drain_neg");

      // three interleaved channels, 2x2
      set_cfg(1, 2, 2, 1'b0);
      for (int i = 0; i < 12; i++)
         din[i] = 10 * (i / 3) + (i % 3);
      dexp[0] = 30; dexp[1] = 31; dexp[2] = 32;
      send_frame(1, 2, 2, 3, 12, 11, 1'b1, 0);
      drain(1, "drain_ch3");

      // odd width and height floor away the trailing column and row
      set_cfg(0, 5, 3, 1'b0);
      load_ramp(15, 1);
      dexp[0] = 7; dexp[1] = 9;
      send_frame(0, 5, 3, 1, 15, 14, 1'b1, 0);
      drain(0, "drain_5x3");

      // output back-pressure 1,0,0 with random input gaps
      set_cfg(0, 4, 4, 1'b0);
      load_ramp(16, 1);
      set_exp4(6, 8, 14, 16);
      stall_mode = 1'b1;
      send_frame(0, 4, 4, 1, 16, 15, 1'b0, 3);
      drain(0, "drain_stall");
      stall_mode = 1'b0;
      @(posedge clk); #1;

      // early s_axis_last on beat 10
      set_exp4(6, 8, 0, 0);
      send_frame(0, 4, 4, 1, 10, 9, 1'b1, 0);
      drain(0, "drain_early_last");
      check("err_after_early_last", int'(err_last[0]), 1);

      set_exp4(6, 8, 14, 16);
      send_frame(0, 4, 4, 1, 16, 15, 1'b1, 0);
      drain(0, "drain_after_err");
      check("err_sticky", int'(err_last[0]), 1);
      err_clr[0] = 1'b1;
      @(posedge clk); #1;
      err_clr[0] = 1'b0;
      check("err_cleared", int'(err_last[0]), 0);

      // expected last beat without s_axis_last still wraps and pools
      send_frame(0, 4, 4, 1, 16, -1, 1'b1, 0);
      drain(0, "drain_missing_last");
      check("err_missing_last", int'(err_last[0]), 1);
      err_clr[0] = 1'b1;
      @(posedge clk); #1;
      err_clr[0] = 1'b0;
      check("err_cleared2", int'(err_last[0]), 0);

      // reset mid-frame with a pooled word on the output
      dexp[0] = 6;
      send_frame(0, 4, 4, 1, 6, -1, 1'b1, 0);
      @(posedge clk); #1;
      check("pre_reset_valid", int'(m_valid[0]), 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midreset_m_valid", int'(m_valid[0]), 0);
      check("midreset_m_data", m_data[0], 0);
      check("midreset_m_last", int'(m_last[0]), 0);
      check("midreset_m_keep", int'(m_keep[0]), 0);
      check("midreset_frame_done", int'(frame_done[0]), 0);
      check("midreset_err_last", int'(err_last[0]), 0);
      q0.delete();
      for (int s = 0; s < 2; s++) begin
         fd_pend[s] = 1'b0;
         prev_st[s] = 1'b0;
      end
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      set_exp4(6, 8, 14, 16);
      send_frame(0, 4, 4, 1, 16, 15, 1'b1, 0);
      drain(0, "drain_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
